// File: rtl/fetch_queue.sv
// fetch_queue: instruction-fetch front end.
// Owns the PC, issues FETCH_WIDTH-word reads into a 1-cycle synchronous
// instruction RAM, applies the branch prediction on the returning bundle and
// buffers instructions in a QUEUE_DEPTH FIFO drained by decode (valid/ready).
// A redirect from exec flushes the queue and any read in flight.
// Optional feature macro: FETCH_QUEUE_BYPASS_EN -- when defined, slot 0 of a
// response arriving at an empty queue is presented on deq_* in the same cycle.
module fetch_queue #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    IMEM_AW     = 15,
  parameter int                    FETCH_WIDTH = 2,
  parameter int                    QUEUE_DEPTH = 8,
  parameter int                    GHR_WIDTH   = 9,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                          clk,
  input  logic                          rst,
  output logic                          imem_en,
  output logic [IMEM_AW-1:0]            imem_addr,
  input  logic [32*FETCH_WIDTH-1:0]     imem_rdata,
  output logic [ADDR_WIDTH-1:0]         pred_pc,
  input  logic                          pred_taken,
  input  logic [ADDR_WIDTH-1:0]         pred_target,
  input  logic [GHR_WIDTH-1:0]          pred_index,
  input  logic                          redirect,
  input  logic [ADDR_WIDTH-1:0]         redirect_pc,
  output logic                          deq_valid,
  input  logic                          deq_ready,
  output logic [ADDR_WIDTH-1:0]         deq_pc,
  output logic [31:0]                   deq_instr,
  output logic                          deq_pred_taken,
  output logic [GHR_WIDTH-1:0]          deq_pred_index,
  output logic [$clog2(QUEUE_DEPTH):0]  count
);

  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [ADDR_WIDTH-1:0] BUNDLE_BYTES = ADDR_WIDTH'(4*FETCH_WIDTH);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [31:0]           instr;
    logic                  taken;
    logic [GHR_WIDTH-1:0]  index;
  } entry_t;

  // architectural state
  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] ipc;
  logic                  inflight;
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         wr_ptr;
  entry_t                q [QUEUE_DEPTH];

  // per-cycle control
  entry_t [FETCH_WIDTH-1:0]          slot;
  entry_t                            head;
  logic                              resp;
  logic                              resp_taken;
  logic                              byp;
  logic                              issue;
  logic                              pop;
  logic [ADDR_WIDTH-1:0]             tgt;
  logic [ADDR_WIDTH-1:0]             fetch_pc;
  logic [ADDR_WIDTH-1:0]             redir_pc;
  logic [FETCH_WIDTH-1:0]            wen;
  logic [FETCH_WIDTH-1:0][PW-1:0]    widx;
  logic [CW-1:0]                     enq_n;
  int                                space;
  int                                slot_lo;
  int                                slot_hi;

  // Targets are word aligned; the two LSBs of incoming addresses carry nothing.
  logic unused_lsbs;
  assign unused_lsbs = ^{pred_target[1:0], redirect_pc[1:0]};
  assign tgt         = {pred_target[ADDR_WIDTH-1:2], 2'b00};
  assign redir_pc    = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};

  // A response is only usable when nothing is flushing the pipe this cycle.
  assign resp       = inflight && !redirect && !rst;
  assign resp_taken = resp && pred_taken;
  assign pred_pc    = inflight ? ipc : pc;

`ifdef FETCH_QUEUE_BYPASS_EN
  assign byp = resp && (count == '0);
`else
  assign byp = 1'b0;
`endif

  // Unpack the returning bundle; the prediction belongs to slot 0 only.
  for (genvar k = 0; k < FETCH_WIDTH; k++) begin : g_slot
    assign slot[k].pc    = ipc + ADDR_WIDTH'(4*k);
    assign slot[k].instr = imem_rdata[32*k +: 32];
    assign slot[k].taken = (k == 0) && pred_taken;
    assign slot[k].index = pred_index;
  end

  // Issue only when the queue can absorb this bundle plus the one in flight.
  always_comb begin
    space    = QUEUE_DEPTH - int'(count) - (inflight ? FETCH_WIDTH : 0);
    issue    = !rst && !redirect && (space >= FETCH_WIDTH);
    fetch_pc = resp_taken ? tgt : pc;
    imem_en  = issue;
    imem_addr = fetch_pc[IMEM_AW+1:2];
  end

  // Select which response slots get written and where they land.
  always_comb begin
    slot_lo = (byp && deq_ready) ? 1 : 0;
    slot_hi = pred_taken ? 1 : FETCH_WIDTH;
    enq_n   = '0;
    wen     = '0;
    widx    = '0;
    if (resp && (slot_hi > slot_lo)) enq_n = CW'(slot_hi - slot_lo);
    for (int k = 0; k < FETCH_WIDTH; k++) begin
      if (resp && (k >= slot_lo) && (k < slot_hi)) begin
        wen[k]  = 1'b1;
        widx[k] = wr_ptr + PW'(k - slot_lo);
      end
    end
  end

  // Head selection and decode handshake; outputs read as zero when not valid.
  always_comb begin
    head           = byp ? slot[0] : q[rd_ptr];
    deq_valid      = !rst && !redirect && (byp || (count != '0));
    pop            = deq_valid && deq_ready && !byp;
    deq_pc         = '0;
    deq_instr      = '0;
    deq_pred_taken = 1'b0;
    deq_pred_index = '0;
    if (deq_valid) begin
      deq_pc         = head.pc;
      deq_instr      = head.instr;
      deq_pred_taken = head.taken;
      deq_pred_index = head.index;
    end
  end

  // PC, in-flight tracking and queue pointers; redirect flushes everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= RESET_PC;
      ipc      <= RESET_PC;
      inflight <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else if (redirect) begin
      pc       <= redir_pc;
      inflight <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      inflight <= issue;
      if (issue) begin
        ipc <= fetch_pc;
        pc  <= fetch_pc + BUNDLE_BYTES;
      end else if (resp_taken) begin
        pc  <= tgt;
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      wr_ptr <= wr_ptr + enq_n[PW-1:0];
      count  <= count + enq_n - CW'(pop);
    end
  end

  // Queue storage; write enables are already gated by reset and redirect.
  always_ff @(posedge clk) begin
    for (int k = 0; k < FETCH_WIDTH; k++) begin
      if (wen[k]) q[widx[k]] <= slot[k];
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed + random checks of fetch_queue against a
// program-order reference model (bundle walk with static branch prediction).
module tb_fetch_queue;
  localparam int AW  = 32;
  localparam int IAW = 15;
  localparam int FW  = 2;
  localparam int QD  = 8;
  localparam int GW  = 9;
`ifdef FETCH_QUEUE_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   imem_en;
  logic [IAW-1:0]         imem_addr;
  logic [32*FW-1:0]       imem_rdata;
  logic [AW-1:0]          pred_pc;
  logic                   pred_taken;
  logic [AW-1:0]          pred_target;
  logic [GW-1:0]          pred_index;
  logic                   redirect;
  logic [AW-1:0]          redirect_pc;
  logic                   deq_valid;
  logic                   deq_ready;
  logic [AW-1:0]          deq_pc;
  logic [31:0]            deq_instr;
  logic                   deq_pred_taken;
  logic [GW-1:0]          deq_pred_index;
  logic [$clog2(QD):0]    count;

  fetch_queue #(
    .ADDR_WIDTH(AW), .IMEM_AW(IAW), .FETCH_WIDTH(FW),
    .QUEUE_DEPTH(QD), .GHR_WIDTH(GW), .RESET_PC('0)
  ) dut (
    .clk(clk), .rst(rst),
    .imem_en(imem_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .pred_pc(pred_pc), .pred_taken(pred_taken), .pred_target(pred_target),
    .pred_index(pred_index),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .deq_valid(deq_valid), .deq_ready(deq_ready), .deq_pc(deq_pc),
    .deq_instr(deq_instr), .deq_pred_taken(deq_pred_taken),
    .deq_pred_index(deq_pred_index), .count(count)
  );

  always #5 clk = ~clk;

  // instruction RAM: word(i) = i, slot k reads word addr+k (wrapping)
  function automatic logic [31:0] word(input logic [IAW-1:0] a);
    return {17'h0, a};
  endfunction

  always @(posedge clk)
    if (imem_en)
      for (int k = 0; k < FW; k++) imem_rdata[32*k +: 32] <= word(imem_addr + IAW'(k));

  // static predictor: one taken branch
  logic          br_en;
  logic [AW-1:0] br_pc;
  logic [AW-1:0] br_tgt;
  assign pred_taken  = br_en && (pred_pc == br_pc);
  assign pred_target = br_tgt;
  assign pred_index  = pred_pc[10:2] ^ 9'h0A5;

  // reference model: expected program-order stream
  typedef struct {
    logic [AW-1:0] pc;
    logic [31:0]   instr;
    logic          taken;
    logic [GW-1:0] index;
  } exp_t;
  exp_t          expq[$];
  logic [AW-1:0] gen_pc;
  int            nchk = 0;
  int            nfail = 0;
  int            npop = 0;
  logic          last_en = 1'b0;
  logic [IAW-1:0] last_addr = '0;
  logic          flushed = 1'b0;

  function automatic void model_reset(input logic [AW-1:0] p);
    expq.delete();
    gen_pc = {p[AW-1:2], 2'b00};
  endfunction

  // one fetch bundle in program order; a taken prediction ends the bundle
  function automatic void gen_bundle();
    exp_t          e;
    logic [AW-1:0] b;
    logic [AW-1:0] a;
    logic          tk;
    b  = gen_pc;
    tk = br_en && (b == br_pc);
    for (int k = 0; k < FW; k++) begin
      a       = b + AW'(4*k);
      e.pc    = a;
      e.instr = word(a[IAW+1:2]);
      e.taken = (k == 0) && tk;
      e.index = b[10:2] ^ 9'h0A5;
      expq.push_back(e);
      if (tk) break;
    end
    gen_pc = tk ? {br_tgt[AW-1:2], 2'b00} : b + AW'(4*FW);
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // check this cycle's outputs, then advance to the next negedge
  task automatic cycle();
    exp_t e;
    #1;
    if (flushed) chk("flush_count", count, 0);
    flushed = 1'b0;
    if (rst) begin
      chk("rst_imem_en", imem_en, 0);
      chk("rst_deq_valid", deq_valid, 0);
      chk("rst_deq_pc", deq_pc, 0);
      chk("rst_deq_instr", deq_instr, 0);
      model_reset('0);
      flushed = 1'b1;
      last_en = 1'b0;
    end else begin
      chk("count_le_depth", count > QD, 0);
      if (last_en && (last_addr == br_pc[IAW+1:2]) && br_en && !redirect && imem_en) begin
        chk("taken_pred_pc", pred_pc, br_pc);
        chk("taken_imem_addr", imem_addr, br_tgt[IAW+1:2]);
      end
      if (redirect) begin
        chk("redirect_deq_valid", deq_valid, 0);
        model_reset(redirect_pc);
        flushed = 1'b1;
        last_en = 1'b0;
      end else begin
        if (deq_valid && deq_ready) begin
          if (expq.size() == 0) gen_bundle();
          e = expq.pop_front();
          npop++;
          chk("deq_pc", deq_pc, e.pc);
          chk("deq_instr", deq_instr, e.instr);
          chk("deq_pred_taken", deq_pred_taken, e.taken);
          chk("deq_pred_index", deq_pred_index, e.index);
        end
        last_en   = imem_en;
        last_addr = imem_addr;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; redirect = 1'b0; redirect_pc = '0; deq_ready = 1'b1;
    br_en = 1'b1; br_pc = 32'h10; br_tgt = 32'h40;
    imem_rdata = '0;
    cycle();
    cycle();
    chk("reset_count", count, 0);

    // release: first issue at RESET_PC, latency depends on bypass
    rst = 1'b0;
    #1;
    chk("first_imem_en", imem_en, 1);
    chk("first_imem_addr", imem_addr, 0);
    chk("first_deq_valid", deq_valid, 0);
    cycle();
    #1;
    chk("resp_deq_valid", deq_valid, BYP);
    chk("resp_deq_pc", deq_valid ? deq_pc : 32'h0, 0);
    cycle();
    #1;
    chk("second_deq_valid", deq_valid, 1);
    // stream through the taken branch at 0x10 -> 0x40
    repeat (20) cycle();

    // backpressure: queue fills, issue stops, then drains in order
    redirect = 1'b1; redirect_pc = 32'h200;
    cycle();
    redirect = 1'b0; deq_ready = 1'b0;
    repeat (12) cycle();
    chk("bp_count", count, QD);
    chk("bp_imem_en", imem_en, 0);
    deq_ready = 1'b1;
    repeat (30) cycle();

    // redirect with five entries queued and a read in flight
    redirect = 1'b1; redirect_pc = 32'h300;
    cycle();
    redirect = 1'b0; deq_ready = 1'b0;
    cycle();
    cycle();
    deq_ready = 1'b1;
    cycle();
    deq_ready = 1'b0;
    cycle();
    chk("pre_redirect_count", count, 5);
    redirect = 1'b1; redirect_pc = 32'h103; deq_ready = 1'b1;
    cycle();
    redirect = 1'b0;
    repeat (12) cycle();

    // random backpressure, redirects and occasional reset
    for (int i = 0; i < 500; i++) begin
      deq_ready   = ($urandom_range(0, 3) != 0);
      redirect    = ($urandom_range(0, 39) == 0);
      redirect_pc = AW'($urandom_range(0, 32'hFFF));
      rst         = ($urandom_range(0, 149) == 0);
      cycle();
    end
    rst = 1'b0; redirect = 1'b0; deq_ready = 1'b1;
    repeat (20) cycle();
    chk("pops_seen", npop > 200, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
Parametrised instruction-fetch front end that replaces the single-register fetch stage plus FD latch. It owns the PC, issues reads into the synchronous dual-read instruction RAM (1-cycle latency, FETCH_WIDTH consecutive words per read) and applies the GShare prediction on the returned bundle. Fetched instructions are buffered in a QUEUE_DEPTH FIFO that decode drains with a valid/ready handshake. Exec-stage misprediction redirect flushes the queue and any in-flight read.

Parameters:
ADDR_WIDTH, 32, PC width in bits.
IMEM_AW, 15, instruction RAM word-address width; imem_addr = pc[IMEM_AW+1:2].
FETCH_WIDTH, 2, instructions per read (1 or 2); slot k is word pc+4k, with word address wrapping modulo 2^IMEM_AW.
QUEUE_DEPTH, 8, FIFO entries; power of 2, at least 2*FETCH_WIDTH.
GHR_WIDTH, 9, width of the predictor index carried with each instruction.
RESET_PC, 0, PC after reset.

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
imem_en  out  1  read strobe to instruction RAM
imem_addr  out  IMEM_AW  word address of slot 0
imem_rdata  in  32*FETCH_WIDTH  read data one cycle after imem_en; slot k at bits [32k+31:32k]
pred_pc  out  ADDR_WIDTH  PC of the bundle currently returning; drives the predictor
pred_taken  in  1  predictor direction for pred_pc, combinational
pred_target  in  ADDR_WIDTH  predicted target for pred_pc
pred_index  in  GHR_WIDTH  pc XOR history index for pred_pc
redirect  in  1  exec misprediction
redirect_pc  in  ADDR_WIDTH  corrected next PC
deq_valid  out  1  head entry valid
deq_ready  in  1  decode accepts the head entry
deq_pc  out  ADDR_WIDTH  head PC
deq_instr  out  32  head instruction
deq_pred_taken  out  1  prediction attached to the head entry
deq_pred_index  out  GHR_WIDTH  predictor index attached to the head entry
count  out  $clog2(QUEUE_DEPTH)+1  queue occupancy

Behaviour:
- Reset: pc=RESET_PC, queue empty, count=0, inflight=0. During reset imem_en=0, deq_valid=0 and all deq_* outputs are 0.
- State: pc register, inflight flag with its issue PC (ipc), circular queue with rd/wr pointers wrapping at QUEUE_DEPTH, and count.
- Response cycle: the cycle after an issue, when inflight=1. In that cycle pred_pc=ipc; otherwise pred_pc=pc.
- Enqueue on a response, slot 0 first:
  - Slot k is written with pc ipc+4k and pred_index.
  - pred_taken is attached to slot 0 only.
  - If pred_taken=1, slot 0 is the last slot enqueued (later slots are dropped).
- Issue condition: !rst && !redirect && (QUEUE_DEPTH - count - (inflight ? FETCH_WIDTH : 0)) >= FETCH_WIDTH. Space is reserved for the in-flight bundle, so there is never an overflow.
- Issue address (zero-bubble predicted fetch):
  - If a response with pred_taken arrives in the same cycle: imem_addr=pred_target, and pc <= pred_target + 4*FETCH_WIDTH.
  - Otherwise: imem_addr=pc, and pc <= pc + 4*FETCH_WIDTH.
  - If no issue happens, a taken response still loads pc <= pred_target.
- Dequeue: when deq_valid && deq_ready, pop one entry.
- count: count_next = count + enq_slots - pop. Enqueue and pop in the same cycle are legal, including when the queue is full.
- Redirect (highest priority):
  - In the redirect cycle: deq_valid forced to 0, no pop, no issue, and any returning response is discarded.
  - Next cycle: queue empty, inflight=0, pc=redirect_pc, and an issue from redirect_pc is allowed.
- redirect_pc and pred_target have bits [1:0] ignored (treated as 0).
- rst asserted mid-operation: same as reset; all state is cleared the next cycle.

Optional Feature:
FETCH_QUEUE_BYPASS_EN.
- Defined: when the queue is empty and a non-discarded response arrives, slot 0 drives the deq_* outputs and deq_valid in that same cycle. If deq_ready=1, slot 0 is consumed without being written; the remaining slots are still enqueued. First-instruction latency is 1 cycle.
- Undefined: a response is always written into the queue first, so deq_valid asserts one cycle later (2-cycle latency).

Test Plan:
- Reset release, deq_ready=1, imem filled with word(i)=i: first issue at addr 0; deq_pc sequence 0x0,0x4,0x8,0xC... with deq_instr 0,1,2,3. Without bypass, first deq_valid is 2 cycles after release.
- Backpressure, deq_ready=0, QUEUE_DEPTH=8, W=2: count saturates at 8, imem_en stays 0 once reserved space runs out. Raise deq_ready: order is preserved with no duplicates.
- Taken prediction, W=2: bundle at 0x10 returns pred_taken=1, pred_target=0x40. Deq order is 0x10,0x40,0x44; 0x14 never appears. imem_addr=0x10 (0x40>>2) in the response cycle.
- Redirect with 5 entries queued and a read in flight: redirect=1, redirect_pc=0x100. deq_valid=0 that cycle, count=0 next cycle; the next deq_pc is 0x100 and no stale instruction appears.
- Wrap-around, QUEUE_DEPTH=4, W=1, random deq_ready: 20 instructions pass through in order, with count never exceeding 4.
- FETCH_QUEUE_BYPASS_EN defined: deq_valid is 1 in the first response cycle with deq_pc=RESET_PC, and count stays 0 for W=1 when deq_ready=1.
